// File: rtl/cpu_control_unit.sv
// cpu_control_unit: registered opcode/func decoder for the single-cycle datapath; optional illegal_op output enabled by CU_ILLEGAL_DETECT_EN
module cpu_control_unit #(
  parameter logic [4:0] ADD_OP = 5'b00000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [4:0] func,
  output logic [1:0] regDst,
  output logic       regWrite,
  output logic       memRead,
  output logic       memWrite,
  output logic [1:0] memToReg,
  output logic       ALUsrc,
  output logic [4:0] ALUop,
  output logic       ALUsel,
  output logic       branch,
  output logic       jumpAddr,
  output logic       lblSel
`ifdef CU_ILLEGAL_DETECT_EN
  , output logic     illegal_op
`endif
);
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ITYPE = 6'b000001;
  localparam logic [5:0] OP_LW    = 6'b000010;
  localparam logic [5:0] OP_SW    = 6'b000011;
  localparam logic [5:0] OP_B     = 6'b000100;
  localparam logic [5:0] OP_BCOND = 6'b000101;
  localparam logic [5:0] OP_BR    = 6'b000110;
  localparam logic [5:0] OP_BL    = 6'b000111;
  logic [1:0] dRegDst;
  logic       dRegWrite;
  logic       dMemRead;
  logic       dMemWrite;
  logic [1:0] dMemToReg;
  logic       dALUsrc;
  logic [4:0] dALUop;
  logic       dALUsel;
  logic       dBranch;
  logic       dJumpAddr;
  logic       dLblSel;
  logic       illegal;
  // decode the current opcode/func into next-cycle steering; illegal encodings collapse to the NOP vector
  always_comb begin
    dRegDst   = 2'b00;
    dRegWrite = 1'b0;
    dMemRead  = 1'b0;
    dMemWrite = 1'b0;
    dMemToReg = 2'b00;
    dALUsrc   = 1'b0;
    dALUop    = 5'b00000;
    dALUsel   = 1'b0;
    dBranch   = 1'b0;
    dJumpAddr = 1'b0;
    dLblSel   = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        illegal   = func > 5'b01001;
        dRegWrite = 1'b1;
        dALUop    = func;
        dALUsel   = (func == 5'b00100) || (func == 5'b00101) || (func == 5'b01000);
      end
      OP_ITYPE: begin
        illegal   = func > 5'b00001;
        dRegWrite = 1'b1;
        dRegDst   = 2'b01;
        dALUsrc   = 1'b1;
        dALUop    = func;
      end
      OP_LW: begin
        dRegWrite = 1'b1;
        dRegDst   = 2'b01;
        dMemRead  = 1'b1;
        dMemToReg = 2'b01;
        dALUsrc   = 1'b1;
        dALUop    = ADD_OP;
      end
      OP_SW: begin
        dMemWrite = 1'b1;
        dALUsrc   = 1'b1;
        dALUop    = ADD_OP;
      end
      OP_B: begin
        dBranch = 1'b1;
        dLblSel = 1'b1;
      end
      OP_BCOND: begin
        illegal = func > 5'b00010;
        dBranch = 1'b1;
        dALUop  = {2'b10, func[2:0]};
      end
      OP_BR: begin
        dBranch   = 1'b1;
        dJumpAddr = 1'b1;
      end
      OP_BL: begin
        dBranch   = 1'b1;
        dLblSel   = 1'b1;
        dRegWrite = 1'b1;
        dRegDst   = 2'b10;
        dMemToReg = 2'b10;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      dRegDst   = 2'b00;
      dRegWrite = 1'b0;
      dMemRead  = 1'b0;
      dMemWrite = 1'b0;
      dMemToReg = 2'b00;
      dALUsrc   = 1'b0;
      dALUop    = 5'b00000;
      dALUsel   = 1'b0;
      dBranch   = 1'b0;
      dJumpAddr = 1'b0;
      dLblSel   = 1'b0;
    end
  end
  // register the decoded vector once per clock; reset forces the NOP vector immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regDst   <= 2'b00;
      regWrite <= 1'b0;
      memRead  <= 1'b0;
      memWrite <= 1'b0;
      memToReg <= 2'b00;
      ALUsrc   <= 1'b0;
      ALUop    <= 5'b00000;
      ALUsel   <= 1'b0;
      branch   <= 1'b0;
      jumpAddr <= 1'b0;
      lblSel   <= 1'b0;
    end else begin
      regDst   <= dRegDst;
      regWrite <= dRegWrite;
      memRead  <= dMemRead;
      memWrite <= dMemWrite;
      memToReg <= dMemToReg;
      ALUsrc   <= dALUsrc;
      ALUop    <= dALUop;
      ALUsel   <= dALUsel;
      branch   <= dBranch;
      jumpAddr <= dJumpAddr;
      lblSel   <= dLblSel;
    end
  end
`ifdef CU_ILLEGAL_DETECT_EN
  // flag illegal encodings alongside the NOP vector they produce
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_op <= 1'b0;
    else illegal_op <= illegal;
  end
`endif
endmodule

// File: tb/tb_cpu_control_unit.sv
// tb_cpu_control_unit: table-driven scoreboard bench for cpu_control_unit
module tb_cpu_control_unit;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic [4:0] func = 5'd0;
  logic [1:0] regDst;
  logic       regWrite;
  logic       memRead;
  logic       memWrite;
  logic [1:0] memToReg;
  logic       ALUsrc;
  logic [4:0] ALUop;
  logic       ALUsel;
  logic       branch;
  logic       jumpAddr;
  logic       lblSel;
  logic       illegalOp;
  int errors = 0;
  int checks = 0;

  cpu_control_unit dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func),
    .regDst(regDst), .regWrite(regWrite), .memRead(memRead), .memWrite(memWrite),
    .memToReg(memToReg), .ALUsrc(ALUsrc), .ALUop(ALUop), .ALUsel(ALUsel),
    .branch(branch), .jumpAddr(jumpAddr), .lblSel(lblSel)
`ifdef CU_ILLEGAL_DETECT_EN
    , .illegal_op(illegalOp)
`endif
  );
`ifndef CU_ILLEGAL_DETECT_EN
  assign illegalOp = 1'b0;
`endif

  always #5 clk = ~clk;

  // packed order: regDst,regWrite,memRead,memWrite,memToReg,ALUsrc,ALUop,ALUsel,branch,jumpAddr,lblSel
  logic [16:0] got;
  assign got = {regDst, regWrite, memRead, memWrite, memToReg, ALUsrc, ALUop, ALUsel, branch, jumpAddr, lblSel};

  function automatic logic [16:0] v(input logic [1:0] rd, input logic rw, input logic mr, input logic mw,
                                    input logic [1:0] m2r, input logic src, input logic [4:0] op,
                                    input logic sel, input logic br, input logic ja, input logic lbl);
    return {rd, rw, mr, mw, m2r, src, op, sel, br, ja, lbl};
  endfunction

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  fn;
    logic [16:0] exp;
    logic        ill;
  } vec_t;

  typedef struct {
    string       name;
    logic [16:0] exp;
    logic        ill;
  } sb_t;

  vec_t vecs[22];
  sb_t  sbq[$];

  task automatic chk(input string name, input logic [16:0] act, input logic [16:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkIll(input string name, input logic exp);
`ifdef CU_ILLEGAL_DETECT_EN
    checks++;
    if (illegalOp !== exp) begin
      errors++;
      $display("FAIL %s illegal_op: got %b expected %b", name, illegalOp, exp);
    end
`else
    if (exp && 1'b0) $display("%s", name);
`endif
  endtask

  // drive one instruction before the edge, queue its expectation, compare after the edge
  task automatic issue(input string name, input logic [5:0] op, input logic [4:0] fn,
                       input logic [16:0] exp, input logic ill);
    sb_t s;
    @(negedge clk);
    opcode = op;
    func = fn;
    sbq.push_back('{name, exp, ill});
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      s = sbq.pop_front();
      chk(s.name, got, s.exp);
      chkIll(s.name, s.ill);
      checks++;
      if ((memRead && memWrite) || (regWrite && memWrite)) begin
        errors++;
        $display("FAIL %s exclusion: got mr=%b mw=%b rw=%b expected no overlap", name, memRead, memWrite, regWrite);
      end
    end
  endtask

  initial begin
    vecs[0]  = '{6'd0, 5'd0,  v(2'd0, 1, 0, 0, 2'd0, 0, 5'd0,  0, 0, 0, 0), 0};
    vecs[1]  = '{6'd0, 5'd4,  v(2'd0, 1, 0, 0, 2'd0, 0, 5'd4,  1, 0, 0, 0), 0};
    vecs[2]  = '{6'd0, 5'd5,  v(2'd0, 1, 0, 0, 2'd0, 0, 5'd5,  1, 0, 0, 0), 0};
    vecs[3]  = '{6'd0, 5'd6,  v(2'd0, 1, 0, 0, 2'd0, 0, 5'd6,  0, 0, 0, 0), 0};
    vecs[4]  = '{6'd0, 5'd8,  v(2'd0, 1, 0, 0, 2'd0, 0, 5'd8,  1, 0, 0, 0), 0};
    vecs[5]  = '{6'd0, 5'd9,  v(2'd0, 1, 0, 0, 2'd0, 0, 5'd9,  0, 0, 0, 0), 0};
    vecs[6]  = '{6'd0, 5'd10, 17'd0, 1};
    vecs[7]  = '{6'd0, 5'd31, 17'd0, 1};
    vecs[8]  = '{6'd1, 5'd0,  v(2'd1, 1, 0, 0, 2'd0, 1, 5'd0,  0, 0, 0, 0), 0};
    vecs[9]  = '{6'd1, 5'd1,  v(2'd1, 1, 0, 0, 2'd0, 1, 5'd1,  0, 0, 0, 0), 0};
    vecs[10] = '{6'd1, 5'd2,  17'd0, 1};
    vecs[11] = '{6'd2, 5'd3,  v(2'd1, 1, 1, 0, 2'd1, 1, 5'd0,  0, 0, 0, 0), 0};
    vecs[12] = '{6'd3, 5'd7,  v(2'd0, 0, 0, 1, 2'd0, 1, 5'd0,  0, 0, 0, 0), 0};
    vecs[13] = '{6'd4, 5'd0,  v(2'd0, 0, 0, 0, 2'd0, 0, 5'd0,  0, 1, 0, 1), 0};
    vecs[14] = '{6'd5, 5'd0,  v(2'd0, 0, 0, 0, 2'd0, 0, 5'd16, 0, 1, 0, 0), 0};
    vecs[15] = '{6'd5, 5'd1,  v(2'd0, 0, 0, 0, 2'd0, 0, 5'd17, 0, 1, 0, 0), 0};
    vecs[16] = '{6'd5, 5'd2,  v(2'd0, 0, 0, 0, 2'd0, 0, 5'd18, 0, 1, 0, 0), 0};
    vecs[17] = '{6'd5, 5'd3,  17'd0, 1};
    vecs[18] = '{6'd6, 5'd0,  v(2'd0, 0, 0, 0, 2'd0, 0, 5'd0,  0, 1, 1, 0), 0};
    vecs[19] = '{6'd7, 5'd0,  v(2'd2, 1, 0, 0, 2'd2, 0, 5'd0,  0, 1, 0, 1), 0};
    vecs[20] = '{6'd8, 5'd0,  17'd0, 1};
    vecs[21] = '{6'd63, 5'd31, 17'd0, 1};

    opcode = 6'd2;
    func = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hold", got, 17'd0);
    chkIll("reset_hold", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    issue("lw_after_release", 6'd2, 5'd0, v(2'd1, 1, 1, 0, 2'd1, 1, 5'd0, 0, 0, 0, 0), 0);

    foreach (vecs[i]) issue($sformatf("vec%0d_op%0d_fn%0d", i, vecs[i].op, vecs[i].fn),
                            vecs[i].op, vecs[i].fn, vecs[i].exp, vecs[i].ill);

    issue("addi", 6'd1, 5'd0, v(2'd1, 1, 0, 0, 2'd0, 1, 5'd0, 0, 0, 0, 0), 0);
    issue("sw_after_addi", 6'd3, 5'd0, v(2'd0, 0, 0, 1, 2'd0, 1, 5'd0, 0, 0, 0, 0), 0);

    issue("bl_active", 6'd7, 5'd0, v(2'd2, 1, 0, 0, 2'd2, 0, 5'd0, 0, 1, 0, 1), 0);
    opcode = 6'd3;
    #2;
    chk("hold_between_edges", got, v(2'd2, 1, 0, 0, 2'd2, 0, 5'd0, 0, 1, 0, 1));
    rst_n = 1'b0;
    #1;
    chk("async_reset_mid_cycle", got, 17'd0);
    @(posedge clk);
    #1;
    chk("reset_over_edge", got, 17'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue("first_edge_after_release", 6'd6, 5'd0, v(2'd0, 0, 0, 0, 2'd0, 0, 5'd0, 0, 1, 1, 0), 0);
    issue("illegal_after_br", 6'd63, 5'd0, 17'd0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
